// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Sends one byte per valid/ready handshake as
// start bit, 5..8 data bits LSB first, optional parity bit, one stop bit.
// Bit period is selected per frame from DIV0..DIV3 via baud_sel.
//
// Ports:
//   clk, rst            system clock (rising edge), synchronous active-high reset
//   tx_data, tx_valid   byte to send and its valid strobe
//   tx_ready            high while idle; the byte is accepted on valid && ready
//   tx_done             one-cycle pulse in the idle cycle after each stop bit
//   parity_en/odd       parity enable and sense (0 = even, 1 = odd)
//   frame_len           data bits: 00=5, 01=6, 10=7, 11=8
//   baud_sel            selects DIV0..DIV3 clocks per bit
//   tx                  serial line, idle high
//   debug_frame         only with UART_TX_DEBUG_EN: {parity, data} of last frame
module uart_tx #(
    parameter int unsigned DIV0  = 32,
    parameter int unsigned DIV1  = 64,
    parameter int unsigned DIV2  = 16,
    parameter int unsigned DIV3  = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic [1:0] frame_len,
    input  logic [1:0] baud_sel,
    output logic       tx
`ifdef UART_TX_DEBUG_EN
    ,
    output logic [8:0] debug_frame
`endif
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic             accept, done_n, tx_n, ready_n;

    // Frame settings captured at acceptance
    logic [7:0]       data_q;
    logic             par_en_q, par_odd_q;
    logic [1:0]       len_q;
    logic [CNT_W-1:0] div_q;

    logic [CNT_W-1:0] div_sel;
    logic [7:0]       mask;
    logic [2:0]       last_idx;
    logic             par_bit, bit_end;

    // Terminal count (DIV-1) for the requested baud rate
    always_comb begin
        div_sel = CNT_W'(DIV0 - 1);
        case (baud_sel)
            2'b01:   div_sel = CNT_W'(DIV1 - 1);
            2'b10:   div_sel = CNT_W'(DIV2 - 1);
            2'b11:   div_sel = CNT_W'(DIV3 - 1);
            default: div_sel = CNT_W'(DIV0 - 1);
        endcase
    end

    // Only the N in-frame data bits feed parity and debug capture
    assign mask     = 8'hFF >> (2'd3 - len_q);
    assign last_idx = 3'd4 + {1'b0, len_q};
    assign par_bit  = (^(data_q & mask)) ^ par_odd_q;
    assign bit_end  = (cnt == div_q);

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        accept  = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    accept  = 1'b1;
                    state_n = START;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            end
            START: begin
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == last_idx) begin
                        idx_n   = '0;
                        state_n = par_en_q ? PARITY : STOP;
                    end else begin
                        idx_n = 3'(idx + 3'd1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_n = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (state != IDLE) cnt_n = bit_end ? '0 : CNT_W'(cnt + 1'b1);

        // Line level for the cycle after this edge
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = data_q[idx_n];
            PARITY:  tx_n = par_bit;
            default: tx_n = 1'b1;
        endcase
        ready_n = (state_n == IDLE);
    end

    // State, counters, registered outputs and latched frame settings
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            tx        <= 1'b1;
            tx_ready  <= 1'b1;
            tx_done   <= 1'b0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            len_q     <= '0;
            div_q     <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            tx       <= tx_n;
            tx_ready <= ready_n;
            tx_done  <= done_n;
            if (accept) begin
                data_q    <= tx_data;
                par_en_q  <= parity_en;
                par_odd_q <= parity_odd;
                len_q     <= frame_len;
                div_q     <= div_sel;
            end
        end
    end

`ifdef UART_TX_DEBUG_EN
    // Snapshot of the completed frame, visible in the tx_done cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            debug_frame <= '0;
        end else if (done_n) begin
            debug_frame <= {par_en_q & par_bit, data_q & mask};
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed, table-driven bench for uart_tx.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       parity_en;
    logic       parity_odd;
    logic [1:0] frame_len;
    logic [1:0] baud_sel;
    logic       tx;
`ifdef UART_TX_DEBUG_EN
    logic [8:0] debug_frame;
`endif

    int checks   = 0;
    int failures = 0;

    uart_tx dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .frame_len  (frame_len),
        .baud_sel   (baud_sel),
        .tx         (tx)
`ifdef UART_TX_DEBUG_EN
        ,
        .debug_frame(debug_frame)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        po;
        logic [1:0]  len;
        logic [1:0]  baud;
        logic [11:0] line;   // expected line bits in send order, bit 0 = start
        int          nbits;  // start + data + parity + stop
        int          div;
        logic [8:0]  dbg;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Called at the negedge of the first start-bit cycle; returns at the
    // negedge of the tx_done cycle.
    task automatic run_frame(input string name, input logic [11:0] line,
                             input int nbits, input int div);
        for (int b = 0; b < nbits; b++) begin
            int bad = 0;
            for (int c = 0; c < div; c++) begin
                if (tx !== line[b] || tx_ready !== 1'b0 || tx_done !== 1'b0) bad++;
                @(negedge clk);
            end
            chk($sformatf("%s_bit%0d_badcycles", name, b), 32'(bad), 32'd0);
        end
        chk($sformatf("%s_done_ready_tx", name), {29'd0, tx_done, tx_ready, tx}, 32'h7);
    endtask

    // Present a byte for one handshake and move to the first start-bit cycle
    task automatic send(input logic [7:0] d, input logic pe, input logic po,
                        input logic [1:0] len, input logic [1:0] baud);
        tx_data    = d;
        parity_en  = pe;
        parity_odd = po;
        frame_len  = len;
        baud_sel   = baud;
        tx_valid   = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; parity_en = 1'b0;
        parity_odd = 1'b0; frame_len = 2'b11; baud_sel = 2'b00;

        vecs[0] = '{8'h90, 1'b0, 1'b0, 2'b11, 2'b00, 12'h320, 10, 32, 9'h090};
        vecs[1] = '{8'h9F, 1'b1, 1'b0, 2'b11, 2'b00, 12'h53E, 11, 32, 9'h09F};
        vecs[2] = '{8'h9F, 1'b1, 1'b1, 2'b11, 2'b00, 12'h73E, 11, 32, 9'h19F};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 2'b10, 2'b00, 12'h3FE, 10, 32, 9'h17F};
        vecs[4] = '{8'hE5, 1'b1, 1'b1, 2'b00, 2'b01, 12'h0CA,  8, 64, 9'h105};
        vecs[5] = '{8'hEA, 1'b0, 1'b0, 2'b01, 2'b10, 12'h0D4,  8, 16, 9'h02A};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_tx_ready_done", {29'd0, tx, tx_ready, tx_done}, 32'h6);
`ifdef UART_TX_DEBUG_EN
        chk("reset_debug", 32'(debug_frame), 32'h0);
`endif
        @(negedge clk);

        // Single frames from the table
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].data, vecs[i].pe, vecs[i].po, vecs[i].len, vecs[i].baud);
            run_frame($sformatf("vec%0d", i), vecs[i].line, vecs[i].nbits, vecs[i].div);
`ifdef UART_TX_DEBUG_EN
            chk($sformatf("vec%0d_debug", i), 32'(debug_frame), 32'(vecs[i].dbg));
`endif
            @(negedge clk);
            chk($sformatf("vec%0d_idle_after", i), {29'd0, tx, tx_ready, tx_done}, 32'h6);
            @(negedge clk);
        end

        // Back-to-back with tx_valid held high, 8 clocks per bit
        tx_data = 8'h55; parity_en = 1'b0; parity_odd = 1'b0;
        frame_len = 2'b11; baud_sel = 2'b11; tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'hAA;
        run_frame("b2b_first", 12'h2AA, 10, 8);
        @(negedge clk);
        tx_valid = 1'b0;
        run_frame("b2b_second", 12'h354, 10, 8);
        @(negedge clk);
        @(negedge clk);

        // Settings changed mid-frame apply only to the following frame
        send(8'h90, 1'b0, 1'b0, 2'b11, 2'b00);
        tx_data = 8'h0F; parity_en = 1'b1; baud_sel = 2'b11;
        run_frame("midcfg_first", 12'h320, 10, 32);
        @(negedge clk);
        @(negedge clk);
        send(8'h0F, 1'b1, 1'b0, 2'b11, 2'b11);
        run_frame("midcfg_second", 12'h41E, 11, 8);
        @(negedge clk);
        @(negedge clk);

        // Reset during DATA bit 3 aborts the frame
        send(8'h90, 1'b0, 1'b0, 2'b11, 2'b11);
        repeat (8 + 3 * 8 + 3) @(negedge clk);
        chk("abort_in_frame_ready", 32'(tx_ready), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_tx_ready_done", {29'd0, tx, tx_ready, tx_done}, 32'h6);
`ifdef UART_TX_DEBUG_EN
        chk("abort_debug", 32'(debug_frame), 32'h0);
`endif
        begin
            int bad = 0;
            for (int c = 0; c < 120; c++) begin
                @(negedge clk);
                if (tx_done !== 1'b0 || tx !== 1'b1 || tx_ready !== 1'b1) bad++;
            end
            chk("abort_no_done_idle", 32'(bad), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
